// File: rtl/peripheral_bfm_monitor_axi4.sv
// -----------------------------------------------------------------------------
// peripheral_bfm_monitor_axi4
//   Passive AXI4 protocol monitor for the BFM bench. It observes every AW, W,
//   B, AR and R wire between the master and slave BFMs and drives nothing on
//   the bus. It checks the handshake and burst rules. The first violation sets
//   a sticky protocol_error and records its code. It also counts completed
//   write and read transactions.
//
// Ports
//   aclk, aresetn        bus clock (rising edge); async active-low reset
//   aw*/w*/b*/ar*/r*     every channel signal of the bench bus (inputs only)
//   protocol_error       sticky flag: a rule was violated since reset
//   err_code             code of that first violation (0 = none)
//   wr_txn_count         number of B handshakes (wraps)
//   rd_txn_count         number of R handshakes carrying rlast (wraps)
//
// Error codes (the lowest number wins when several fire in one cycle)
//   1 valid dropped while stalled     2 payload changed while stalled
//   3 wlast misplaced                 4 rlast misplaced
//   5 B with no completed write       6 R with no outstanding read
//   7 queue / pending-B overflow      8 ID mismatch (optional)
//   9 W beat with no address
//
// Configuration
//   PERIPHERAL_BFM_MONITOR_ID_CHECK_EN : when defined, the monitor stores IDs
//   and raises code 8. It compares bid with the awid of the oldest write whose
//   data is complete. It compares rid with the ID at the head of the AR queue.
// -----------------------------------------------------------------------------
module peripheral_bfm_monitor_axi4 #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awadr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [ID_W-1:0]       wid,
  input  logic [DATA_W-1:0]     wrdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  input  logic                  rready,
  output logic                  protocol_error,
  output logic [3:0]            err_code,
  output logic [CNT_W-1:0]      wr_txn_count,
  output logic [CNT_W-1:0]      rd_txn_count
);

  localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OCC_W  = PTR_W + 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int AX_PW  = ID_W + ADDR_W + 4 + 3 + 2;
  localparam int W_PW   = ID_W + DATA_W + STRB_W + 1;
  localparam int B_PW   = ID_W + 2;
  localparam int R_PW   = ID_W + DATA_W + 2 + 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUT);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Handshakes and packed payloads used by the stability checks
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [AX_PW-1:0] aw_pay, ar_pay;
  logic [W_PW-1:0]  w_pay;
  logic [B_PW-1:0]  b_pay;
  logic [R_PW-1:0]  r_pay;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign aw_pay = {awid, awadr, awlen, awsize, awburst};
  assign w_pay  = {wid, wrdata, wstrb, wlast};
  assign b_pay  = {bid, bresp};
  assign ar_pay = {arid, araddr, arlen, arsize, arburst};
  assign r_pay  = {rid, rdata, rresp, rlast};

  // Previous-cycle snapshot. snap_ok stays low for the first edge after
  // reset release, because no valid history exists at that edge.
  logic snap_ok;
  logic prev_awvalid, prev_awready, prev_wvalid, prev_wready, prev_bvalid;
  logic prev_bready, prev_arvalid, prev_arready, prev_rvalid, prev_rready;
  logic [AX_PW-1:0] prev_aw_pay, prev_ar_pay;
  logic [W_PW-1:0]  prev_w_pay;
  logic [B_PW-1:0]  prev_b_pay;
  logic [R_PW-1:0]  prev_r_pay;

  // Outstanding-burst queues (burst lengths) and beat counters
  logic [3:0]       aw_len_q [MAX_OUT];
  logic [3:0]       ar_len_q [MAX_OUT];
  logic [PTR_W-1:0] aw_wr_ptr, aw_rd_ptr, ar_wr_ptr, ar_rd_ptr;
  logic [OCC_W-1:0] aw_count, ar_count, pending_b;
  logic [3:0]       w_beat, r_beat;

  logic aw_empty, aw_full, ar_empty, ar_full;
  logic w_head_valid, aw_push, aw_pop, ar_push, ar_pop;
  logic b_inc, b_push, b_pop;
  logic [3:0] w_head_len, r_head_len;

  assign aw_empty = (aw_count == '0);
  assign aw_full  = (aw_count == OCC_FULL);
  assign ar_empty = (ar_count == '0);
  assign ar_full  = (ar_count == OCC_FULL);

  // A W beat may use an address that is accepted in the same cycle. This
  // applies only when the AW queue is empty, so the incoming address is
  // the head.
  assign w_head_valid = !aw_empty || aw_hs;
  assign w_head_len   = aw_empty ? awlen : aw_len_q[aw_rd_ptr];
  assign r_head_len   = ar_len_q[ar_rd_ptr];

  assign aw_pop  = w_hs && wlast && w_head_valid;
  assign aw_push = aw_hs && (!aw_full || aw_pop);
  assign ar_pop  = r_hs && rlast && !ar_empty;
  assign ar_push = ar_hs && (!ar_full || ar_pop);

  // A completed write creates a pending-B credit. When the counter is full
  // the credit is lost, which is reported as an overflow, unless a B
  // consumes a credit in the same cycle.
  assign b_inc  = aw_pop;
  assign b_pop  = b_hs && (pending_b != '0);
  assign b_push = b_inc && ((pending_b != OCC_FULL) || b_pop);

  // Individual rule checks
  logic aw_stall, w_stall, b_stall, ar_stall, r_stall;
  logic code1, code2, code3, code4, code5, code6, code7, code8, code9;
  logic [3:0] next_code;

  assign aw_stall = prev_awvalid && !prev_awready;
  assign w_stall  = prev_wvalid  && !prev_wready;
  assign b_stall  = prev_bvalid  && !prev_bready;
  assign ar_stall = prev_arvalid && !prev_arready;
  assign r_stall  = prev_rvalid  && !prev_rready;

  assign code1 = (aw_stall && !awvalid) || (w_stall && !wvalid) ||
                 (b_stall && !bvalid) || (ar_stall && !arvalid) ||
                 (r_stall && !rvalid);
  assign code2 = (aw_stall && awvalid && (aw_pay != prev_aw_pay)) ||
                 (w_stall && wvalid && (w_pay != prev_w_pay)) ||
                 (b_stall && bvalid && (b_pay != prev_b_pay)) ||
                 (ar_stall && arvalid && (ar_pay != prev_ar_pay)) ||
                 (r_stall && rvalid && (r_pay != prev_r_pay));
  assign code3 = w_hs && w_head_valid &&
                 ((wlast && (w_beat < w_head_len)) || (!wlast && (w_beat == w_head_len)));
  assign code4 = r_hs && !ar_empty &&
                 ((rlast && (r_beat < r_head_len)) || (!rlast && (r_beat == r_head_len)));
  assign code5 = b_hs && (pending_b == '0);
  assign code6 = r_hs && ar_empty;
  assign code7 = (aw_hs && !aw_push) || (ar_hs && !ar_push) || (b_inc && !b_push);
  assign code9 = w_hs && !w_head_valid;

`ifdef PERIPHERAL_BFM_MONITOR_ID_CHECK_EN
  // ID tracking. The B-ID queue mirrors pending_b. Each completed write
  // pushes its awid. Each accepted B pops one entry.
  logic [ID_W-1:0]  aw_id_q [MAX_OUT];
  logic [ID_W-1:0]  ar_id_q [MAX_OUT];
  logic [ID_W-1:0]  b_id_q  [MAX_OUT];
  logic [PTR_W-1:0] b_wr_ptr, b_rd_ptr;
  logic [ID_W-1:0]  w_head_id;

  assign w_head_id = aw_empty ? awid : aw_id_q[aw_rd_ptr];
  assign code8 = (b_pop && (bid != b_id_q[b_rd_ptr])) ||
                 (r_hs && !ar_empty && (rid != ar_id_q[ar_rd_ptr]));

  // ID storage follows the same pointers as the length queues
  always_ff @(posedge aclk) begin
    if (aw_push) aw_id_q[aw_wr_ptr] <= awid;
    if (ar_push) ar_id_q[ar_wr_ptr] <= arid;
    if (b_push)  b_id_q[b_wr_ptr]   <= w_head_id;
  end

  // B-ID queue pointers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_wr_ptr <= '0;
      b_rd_ptr <= '0;
    end else begin
      if (b_push) b_wr_ptr <= b_wr_ptr + PTR_ONE;
      if (b_pop)  b_rd_ptr <= b_rd_ptr + PTR_ONE;
    end
  end
`else
  assign code8 = 1'b0;
`endif

  // Priority encoder: the lowest-numbered rule that fires is reported
  always_comb begin
    next_code = 4'd0;
    if      (code1) next_code = 4'd1;
    else if (code2) next_code = 4'd2;
    else if (code3) next_code = 4'd3;
    else if (code4) next_code = 4'd4;
    else if (code5) next_code = 4'd5;
    else if (code6) next_code = 4'd6;
    else if (code7) next_code = 4'd7;
    else if (code8) next_code = 4'd8;
    else if (code9) next_code = 4'd9;
  end

  // Burst length storage (no reset needed: occupancy guards every read)
  always_ff @(posedge aclk) begin
    if (aw_push) aw_len_q[aw_wr_ptr] <= awlen;
    if (ar_push) ar_len_q[ar_wr_ptr] <= arlen;
  end

  // Snapshot of the previous cycle for the stability checks
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      snap_ok      <= 1'b0;
      prev_awvalid <= 1'b0;
      prev_awready <= 1'b0;
      prev_wvalid  <= 1'b0;
      prev_wready  <= 1'b0;
      prev_bvalid  <= 1'b0;
      prev_bready  <= 1'b0;
      prev_arvalid <= 1'b0;
      prev_arready <= 1'b0;
      prev_rvalid  <= 1'b0;
      prev_rready  <= 1'b0;
      prev_aw_pay  <= '0;
      prev_w_pay   <= '0;
      prev_b_pay   <= '0;
      prev_ar_pay  <= '0;
      prev_r_pay   <= '0;
    end else begin
      snap_ok      <= 1'b1;
      prev_awvalid <= awvalid;
      prev_awready <= awready;
      prev_wvalid  <= wvalid;
      prev_wready  <= wready;
      prev_bvalid  <= bvalid;
      prev_bready  <= bready;
      prev_arvalid <= arvalid;
      prev_arready <= arready;
      prev_rvalid  <= rvalid;
      prev_rready  <= rready;
      prev_aw_pay  <= aw_pay;
      prev_w_pay   <= w_pay;
      prev_b_pay   <= b_pay;
      prev_ar_pay  <= ar_pay;
      prev_r_pay   <= r_pay;
    end
  end

  // Queue pointers, occupancy, beat counters and the pending-B credit count.
  // A push and a pop in the same cycle leave the occupancy unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      aw_count  <= '0;
      ar_wr_ptr <= '0;
      ar_rd_ptr <= '0;
      ar_count  <= '0;
      pending_b <= '0;
      w_beat    <= '0;
      r_beat    <= '0;
    end else begin
      if (aw_push) aw_wr_ptr <= aw_wr_ptr + PTR_ONE;
      if (aw_pop)  aw_rd_ptr <= aw_rd_ptr + PTR_ONE;
      if (aw_push && !aw_pop)      aw_count <= aw_count + OCC_ONE;
      else if (aw_pop && !aw_push) aw_count <= aw_count - OCC_ONE;

      if (ar_push) ar_wr_ptr <= ar_wr_ptr + PTR_ONE;
      if (ar_pop)  ar_rd_ptr <= ar_rd_ptr + PTR_ONE;
      if (ar_push && !ar_pop)      ar_count <= ar_count + OCC_ONE;
      else if (ar_pop && !ar_push) ar_count <= ar_count - OCC_ONE;

      if (b_push && !b_pop)      pending_b <= pending_b + OCC_ONE;
      else if (b_pop && !b_push) pending_b <= pending_b - OCC_ONE;

      if (w_hs && w_head_valid) w_beat <= wlast ? 4'd0 : w_beat + 4'd1;
      if (r_hs && !ar_empty)    r_beat <= rlast ? 4'd0 : r_beat + 4'd1;
    end
  end

  // Sticky error capture and transaction counters. The counters keep
  // running after an error has been captured.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      protocol_error <= 1'b0;
      err_code       <= 4'd0;
      wr_txn_count   <= '0;
      rd_txn_count   <= '0;
    end else begin
      if (snap_ok && !protocol_error && (next_code != 4'd0)) begin
        protocol_error <= 1'b1;
        err_code       <= next_code;
      end
      if (b_hs)          wr_txn_count <= wr_txn_count + CNT_ONE;
      if (r_hs && rlast) rd_txn_count <= rd_txn_count + CNT_ONE;
    end
  end

endmodule
